// File: rtl/uart_frame_builder.sv
// uart_frame_builder: turns {chan, sample} into an ASCII frame pushed byte-wise into a UART TX FIFO.
// Define FRAME_CHECKSUM_EN to insert a two-hex-digit XOR checksum before CR/LF.
module uart_frame_builder #(
  parameter int FRAME_GAP = 1_000_000,
  parameter int GAP_W     = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [3:0]  chan,
  input  logic [15:0] sample,
  input  logic        tx_full,
  output logic        wr_uart,
  output logic [7:0]  w_data,
  output logic        busy,
  output logic [7:0]  drop_cnt
);
  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, GAP} state_t;
`ifdef FRAME_CHECKSUM_EN
  localparam logic [3:0] LAST = 4'd9;
`else
  localparam logic [3:0] LAST = 4'd7;
`endif
  state_t            r_state;
  logic              r_pending;
  logic [3:0]        r_hold_chan, r_chan, r_idx;
  logic [15:0]       r_hold_sample, r_sample;
  logic [GAP_W-1:0]  r_gap;
  logic [7:0]        w_chr, w_byte;
  function automatic logic [7:0] hex(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
  assign w_chr = (r_chan > 4'd12) ? 8'h3F : hex(r_chan);
  assign busy  = (r_state != IDLE);
`ifdef FRAME_CHECKSUM_EN
  logic [7:0] w_csum;
  assign w_csum = w_chr ^ 8'h3A ^ hex(r_sample[15:12]) ^ hex(r_sample[11:8]) ^
                  hex(r_sample[7:4]) ^ hex(r_sample[3:0]);
`endif
  always_comb begin
    w_byte = 8'h0A;
    case (r_idx)
      4'd0:    w_byte = w_chr;
      4'd1:    w_byte = 8'h3A;
      4'd2:    w_byte = hex(r_sample[15:12]);
      4'd3:    w_byte = hex(r_sample[11:8]);
      4'd4:    w_byte = hex(r_sample[7:4]);
      4'd5:    w_byte = hex(r_sample[3:0]);
`ifdef FRAME_CHECKSUM_EN
      4'd6:    w_byte = hex(w_csum[7:4]);
      4'd7:    w_byte = hex(w_csum[3:0]);
      4'd8:    w_byte = 8'h0D;
`else
      4'd6:    w_byte = 8'h0D;
`endif
      default: w_byte = 8'h0A;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_pending     <= 1'b0;
      r_hold_chan   <= '0;
      r_hold_sample <= '0;
      r_chan        <= '0;
      r_sample      <= '0;
      r_idx         <= '0;
      r_gap         <= '0;
      wr_uart       <= 1'b0;
      w_data        <= '0;
      drop_cnt      <= '0;
    end else begin
      wr_uart <= 1'b0;
      if (sample_valid) begin
        r_hold_chan   <= chan;
        r_hold_sample <= sample;
      end
      // a capture coinciding with LOAD refills the hold register rather than overwriting it
      r_pending <= sample_valid | (r_pending & (r_state != LOAD));
      if (sample_valid && r_pending && r_state != LOAD && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
      case (r_state)
        IDLE: if (r_pending) r_state <= LOAD;
        LOAD: begin
          r_chan   <= r_hold_chan;
          r_sample <= r_hold_sample;
          r_idx    <= '0;
          r_state  <= SEND;
        end
        SEND: if (!tx_full) begin
          wr_uart <= 1'b1;
          w_data  <= w_byte;
          r_state <= WAIT;
        end
        WAIT: if (r_idx == LAST) begin
          r_gap   <= GAP_W'(FRAME_GAP - 1);
          r_state <= GAP;
        end else begin
          r_idx   <= r_idx + 4'd1;
          r_state <= SEND;
        end
        GAP: if (r_gap == '0) r_state <= IDLE; else r_gap <= r_gap - 1'b1;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_frame_builder.sv
// tb_uart_frame_builder: directed table-driven bench for uart_frame_builder with a short frame gap.
module tb_uart_frame_builder;
  localparam int FG = 20;
`ifdef FRAME_CHECKSUM_EN
  localparam int FLEN = 10;
`else
  localparam int FLEN = 8;
`endif
  logic clk = 0, rst = 0, sample_valid = 0, tx_full = 0;
  logic [3:0] chan = 0;
  logic [15:0] sample = 0;
  logic wr_uart, busy;
  logic [7:0] w_data, drop_cnt;
  int cyc = 0, tests = 0, fails = 0;
  logic [7:0] wr_q[$], exp_q[$];
  int t_q[$];
  typedef struct { logic [3:0] c; logic [15:0] s; logic [47:0] b; } vec_t;
  vec_t vecs[6];

  uart_frame_builder #(.FRAME_GAP(FG), .GAP_W(8)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .chan(chan), .sample(sample),
    .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data), .busy(busy), .drop_cnt(drop_cnt));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (wr_uart) begin wr_q.push_back(w_data); t_q.push_back(cyc); end

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin fails++; $display("FAIL %s: got %0h want %0h", name, act, exp); end
  endtask

`ifdef FRAME_CHECKSUM_EN
  function automatic logic [7:0] tb_hex(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h41 + 8'(n) - 8'd10;
  endfunction
`endif

  task automatic build_exp(input logic [47:0] b);
    exp_q.delete();
    for (int i = 5; i >= 0; i--) exp_q.push_back(b[i*8 +: 8]);
`ifdef FRAME_CHECKSUM_EN
    begin
      logic [7:0] x = 0;
      for (int i = 0; i < 6; i++) x ^= exp_q[i];
      exp_q.push_back(tb_hex(x[7:4]));
      exp_q.push_back(tb_hex(x[3:0]));
    end
`endif
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic clear_q();
    wr_q.delete();
    t_q.delete();
  endtask

  task automatic send(input logic [3:0] c, input logic [15:0] s, output int e);
    @(negedge clk);
    chan = c; sample = s; sample_valid = 1;
    @(posedge clk); #1;
    sample_valid = 0;
    e = cyc;
  endtask

  task automatic wait_writes(input int n, input string name);
    int k = 0;
    while (wr_q.size() < n && k < 300) begin @(posedge clk); #2; k++; end
    if (wr_q.size() < n) begin
      tests++; fails++;
      $display("FAIL %s timeout: got %0d writes want %0d", name, wr_q.size(), n);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    do begin @(posedge clk); #2; k++; end while (busy && k < budget);
    if (busy) begin tests++; fails++; $display("FAIL %s idle timeout: busy still 1", name); end
  endtask

  task automatic check_frame(input string name, input int base);
    chk({name, " count"}, wr_q.size(), FLEN);
    for (int i = 0; i < FLEN && i < wr_q.size(); i++) begin
      chk($sformatf("%s byte%0d", name, i), wr_q[i], exp_q[i]);
      if (base >= 0) chk($sformatf("%s time%0d", name, i), t_q[i], base + 3 + 2 * i);
    end
  endtask

  initial begin
    int e, tl;
    vecs[0] = '{4'd3,  16'h0A5F, 48'h333A30413546};
    vecs[1] = '{4'd13, 16'hFFFF, 48'h3F3A46464646};
    vecs[2] = '{4'd12, 16'h0000, 48'h433A30303030};
    vecs[3] = '{4'd9,  16'h1234, 48'h393A31323334};
    vecs[4] = '{4'd10, 16'hBEEF, 48'h413A42454546};
    vecs[5] = '{4'd15, 16'h0000, 48'h3F3A30303030};
    repeat (3) @(negedge clk);
    chk("rst wr_uart", wr_uart, 0);
    chk("rst w_data", w_data, 0);
    chk("rst busy", busy, 0);
    chk("rst drop_cnt", drop_cnt, 0);
    rst = 1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      wait_idle(200, "table");
      clear_q();
      build_exp(vecs[v].b);
      send(vecs[v].c, vecs[v].s, e);
      wait_writes(FLEN, "table");
      check_frame($sformatf("vec%0d", v), e);
    end
    wait_idle(200, "table end");
    chk("no drops after table", drop_cnt, 0);

    clear_q();
    build_exp(48'h333A30413546);
    send(4'd3, 16'h0A5F, e);
    while (cyc < e + 6) @(negedge clk);
    tx_full = 1;
    repeat (20) @(negedge clk);
    tx_full = 0;
    wait_writes(FLEN, "bp");
    check_frame("bp", -1);
    if (t_q.size() > 2) chk("bp resume time", t_q[2], e + 27);
    wait_idle(200, "bp");
    chk("bp total writes", wr_q.size(), FLEN);

    clear_q();
    send(4'd1, 16'h0001, e);
    wait_writes(FLEN, "pre-drop");
    tl = (t_q.size() > 0) ? t_q[t_q.size() - 1] : 0;
    chk("busy in gap", busy, 1);
    clear_q();
    build_exp(48'h353A33333333);
    send(4'd5, 16'h1111, e);
    send(4'd5, 16'h2222, e);
    send(4'd5, 16'h3333, e);
    wait_writes(FLEN, "drop");
    check_frame("drop", -1);
    if (t_q.size() > 0) chk("gap respected", (t_q[0] - tl) >= FG + 3, 1);
    chk("drop_cnt", drop_cnt, 2);
    wait_idle(200, "drop");
    chk("drop total writes", wr_q.size(), FLEN);

    clear_q();
    send(4'd3, 16'h0A5F, e);
    begin
      int k = 0;
      while (wr_q.size() < 3 && k < 100) begin @(negedge clk); #1; k++; end
      do begin @(negedge clk); #1; k++; end while (!wr_uart && k < 100);
      chk("4th byte reached", wr_uart, 1);
    end
    rst = 0;
    #1;
    chk("mid rst wr_uart", wr_uart, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst drop_cnt", drop_cnt, 0);
    chk("bytes before rst", wr_q.size(), 4);
    @(negedge clk);
    rst = 1;
    clear_q();
    build_exp(48'h393A31323334);
    send(4'd9, 16'h1234, e);
    wait_writes(FLEN, "post-rst");
    check_frame("post-rst", e);
    wait_idle(200, "post-rst");

    tx_full = 1;
    for (int i = 0; i < 260; i++) send(4'd2, 16'(i), e);
    chk("drop_cnt saturates", drop_cnt, 8'hFF);
    chk("stalled no write", wr_uart, 0);
    tx_full = 0;
    wait_idle(400, "sat");
    chk("drop_cnt holds", drop_cnt, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
